// File: rtl/rv32i_decode_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the rv32i_decode stage.
// The decode stage is the slave; the surrounding pipeline (or a bench) is the master.
interface rv32i_decode_if;
  logic        flush_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_pc_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic        rd_we_o;
  logic [31:0] imm_o;
  logic        b_sel_imm_o;
  logic [14:0] op_o;
  logic [5:0]  cls_o;
  logic        illegal_o;

  modport slave (
    input  flush_i, instr_i, pc_i, instr_valid_i, dec_ready_i,
    output instr_ready_o, dec_valid_o, dec_pc_o, rs1_o, rs2_o, rd_o, rd_we_o,
           imm_o, b_sel_imm_o, op_o, cls_o, illegal_o
  );

  modport master (
    output flush_i, instr_i, pc_i, instr_valid_i, dec_ready_i,
    input  instr_ready_o, dec_valid_o, dec_pc_o, rs1_o, rs2_o, rd_o, rd_we_o,
           imm_o, b_sel_imm_o, op_o, cls_o, illegal_o
  );
endinterface

// File: rtl/rv32i_decode.sv
// Registered RV32I decode stage: one-entry output register behind a valid/ready handshake,
// producing one-hot ALU op flags, register addresses, immediate and instruction-class flags.
module rv32i_decode #(
  parameter bit X0_NO_WE     = 1'b1,
  parameter bit FENCE_AS_NOP = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  rv32i_decode_if.slave bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [14:0] OP_ADD  = 15'h0001;
  localparam logic [14:0] OP_AND  = 15'h0002;
  localparam logic [14:0] OP_EQ   = 15'h0004;
  localparam logic [14:0] OP_GE   = 15'h0008;
  localparam logic [14:0] OP_GEU  = 15'h0010;
  localparam logic [14:0] OP_LT   = 15'h0020;
  localparam logic [14:0] OP_LTU  = 15'h0040;
  localparam logic [14:0] OP_NE   = 15'h0080;
  localparam logic [14:0] OP_OR   = 15'h0100;
  localparam logic [14:0] OP_RS2I = 15'h0200;
  localparam logic [14:0] OP_SLL  = 15'h0400;
  localparam logic [14:0] OP_SRA  = 15'h0800;
  localparam logic [14:0] OP_SRL  = 15'h1000;
  localparam logic [14:0] OP_SUB  = 15'h2000;
  localparam logic [14:0] OP_XOR  = 15'h4000;

  localparam logic [5:0] CLS_LOAD   = 6'h01;
  localparam logic [5:0] CLS_STORE  = 6'h02;
  localparam logic [5:0] CLS_BRANCH = 6'h04;
  localparam logic [5:0] CLS_JAL    = 6'h08;
  localparam logic [5:0] CLS_JALR   = 6'h10;
  localparam logic [5:0] CLS_AUIPC  = 6'h20;

  // Shared OP / OP-IMM funct3 map; sub only exists in the register form.
  function automatic logic [14:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'd0:    alu_op = (is_reg && alt) ? OP_SUB : OP_ADD;
      3'd1:    alu_op = OP_SLL;
      3'd2:    alu_op = OP_LT;
      3'd3:    alu_op = OP_LTU;
      3'd4:    alu_op = OP_XOR;
      3'd5:    alu_op = alt ? OP_SRA : OP_SRL;
      3'd6:    alu_op = OP_OR;
      default: alu_op = OP_AND;
    endcase
  endfunction

  logic [31:0] w;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_ok;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign w     = bus.instr_i;
  assign f3    = w[14:12];
  assign f7    = w[31:25];
  assign f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
  assign imm_i = {{20{w[31]}}, w[31:20]};
  assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
  assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  assign imm_u = {w[31:12], 12'b0};
  assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

  logic [14:0] op_d;
  logic [5:0]  cls_d;
  logic [31:0] imm_d;
  logic        b_sel_d;
  logic        we_d;
  logic        illegal_d;

  // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    op_d      = '0;
    cls_d     = '0;
    imm_d     = '0;
    b_sel_d   = 1'b0;
    we_d      = 1'b0;
    illegal_d = 1'b0;
    case (w[6:0])
      OPC_OP: begin
        op_d = alu_op(f3, w[30], 1'b1); we_d = 1'b1; illegal_d = !f7_ok;
      end
      OPC_OP_IMM: begin
        op_d = alu_op(f3, w[30], 1'b0); we_d = 1'b1; b_sel_d = 1'b1; imm_d = imm_i;
        if (f3 == 3'd1)      illegal_d = (f7 != 7'b0000000);
        else if (f3 == 3'd5) illegal_d = !f7_ok;
      end
      OPC_BRANCH: begin
        imm_d = imm_b; cls_d = CLS_BRANCH;
        case (f3)
          3'd0:    op_d = OP_EQ;
          3'd1:    op_d = OP_NE;
          3'd4:    op_d = OP_LT;
          3'd5:    op_d = OP_GE;
          3'd6:    op_d = OP_LTU;
          3'd7:    op_d = OP_GEU;
          default: illegal_d = 1'b1;
        endcase
      end
      OPC_LUI:   begin op_d = OP_RS2I; we_d = 1'b1; b_sel_d = 1'b1; imm_d = imm_u; end
      OPC_AUIPC: begin op_d = OP_ADD; we_d = 1'b1; b_sel_d = 1'b1; imm_d = imm_u; cls_d = CLS_AUIPC; end
      OPC_JAL:   begin op_d = OP_ADD; we_d = 1'b1; b_sel_d = 1'b1; imm_d = imm_j; cls_d = CLS_JAL; end
      OPC_JALR: begin
        op_d = OP_ADD; we_d = 1'b1; b_sel_d = 1'b1; imm_d = imm_i; cls_d = CLS_JALR;
        illegal_d = (f3 != 3'd0);
      end
      OPC_LOAD: begin
        op_d = OP_ADD; we_d = 1'b1; b_sel_d = 1'b1; imm_d = imm_i; cls_d = CLS_LOAD;
        illegal_d = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      OPC_STORE: begin
        op_d = OP_ADD; b_sel_d = 1'b1; imm_d = imm_s; cls_d = CLS_STORE;
        illegal_d = (f3 > 3'd2);
      end
      OPC_FENCE: illegal_d = !FENCE_AS_NOP;
      default:   illegal_d = 1'b1;
    endcase
    // An illegal word must not drive the ALU or write the register file.
    if (illegal_d) begin
      op_d = '0; cls_d = '0; we_d = 1'b0; b_sel_d = 1'b0; imm_d = '0;
    end
    if (X0_NO_WE && (w[11:7] == 5'd0)) we_d = 1'b0;
  end

  logic valid_q;
  logic accept;

  assign bus.instr_ready_o = bus.flush_i | ~valid_q | bus.dec_ready_i;
  assign accept            = bus.instr_valid_i & bus.instr_ready_o & ~bus.flush_i;
  assign bus.dec_valid_o   = valid_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)             valid_q <= 1'b0;
    else if (bus.flush_i)     valid_q <= 1'b0;
    else if (accept)          valid_q <= 1'b1;
    else if (bus.dec_ready_i) valid_q <= 1'b0;
  end

  // NOTE: the payload register is reset as well so every output reads 0 out of reset; it loads only on accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.dec_pc_o    <= '0;
      bus.rs1_o       <= '0;
      bus.rs2_o       <= '0;
      bus.rd_o        <= '0;
      bus.rd_we_o     <= 1'b0;
      bus.imm_o       <= '0;
      bus.b_sel_imm_o <= 1'b0;
      bus.op_o        <= '0;
      bus.cls_o       <= '0;
      bus.illegal_o   <= 1'b0;
    end else if (accept) begin
      bus.dec_pc_o    <= bus.pc_i;
      bus.rs1_o       <= w[19:15];
      bus.rs2_o       <= w[24:20];
      bus.rd_o        <= w[11:7];
      bus.rd_we_o     <= we_d;
      bus.imm_o       <= imm_d;
      bus.b_sel_imm_o <= b_sel_d;
      bus.op_o        <= op_d;
      bus.cls_o       <= cls_d;
      bus.illegal_o   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_rv32i_decode.sv
// Self-checking bench for rv32i_decode: directed cases plus randomized traffic checked
// against a mnemonic-level reference decoder and a one-entry handshake model.
module tb_rv32i_decode;
  localparam bit X0_NO_WE     = 1'b1;
  localparam bit FENCE_AS_NOP = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_decode_if bus ();
  rv32i_decode #(.X0_NO_WE(X0_NO_WE), .FENCE_AS_NOP(FENCE_AS_NOP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        b_sel;
    logic [14:0] op;
    logic [5:0]  cls;
    logic        illegal;
  } exp_t;

  string OP_NAMES [15] = '{"add", "and", "eq", "ge", "geu", "lt", "ltu", "ne", "or",
                           "rs2_imm", "sll", "sra", "srl", "sub", "xor"};
  string BR_NAMES [8]  = '{"eq", "ne", "", "", "lt", "ge", "ltu", "geu"};

  int   n_pass = 0;
  int   n_total = 0;
  logic m_valid = 1'b0;
  exp_t m_out = '0;
  logic seen_ready, exp_ready;

  function automatic int op_index(input string mn);
    for (int i = 0; i < 15; i++) if (OP_NAMES[i] == mn) return i;
    return 0;
  endfunction

  function automatic string alu_name(input logic [2:0] f3, input logic alt, input bit is_reg);
    string names [8] = '{"add", "sll", "lt", "ltu", "xor", "srl", "or", "and"};
    if (f3 == 3'd0 && is_reg && alt) return "sub";
    if (f3 == 3'd5 && alt) return "sra";
    return names[f3];
  endfunction

  // Reference decoder: name the operation, then derive flags and immediate value numerically.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e; string mn; byte fmt; bit ok, writes; int imm;
    logic [2:0] f3; logic [6:0] f7;
    f3 = w[14:12]; f7 = w[31:25];
    e = '0; e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    mn = ""; fmt = "N"; ok = 1; writes = 0;
    case (w[6:0])
      7'b0110011: begin fmt = "R"; writes = 1; ok = (f7 == 0 || f7 == 7'h20); mn = alu_name(f3, f7[5], 1); end
      7'b0010011: begin
        fmt = "I"; writes = 1; e.b_sel = 1; mn = alu_name(f3, f7[5], 0);
        if (f3 == 1) ok = (f7 == 0); else if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
      end
      7'b1100011: begin fmt = "B"; mn = BR_NAMES[f3]; ok = (mn != ""); e.cls[2] = 1; end
      7'b0110111: begin fmt = "U"; writes = 1; e.b_sel = 1; mn = "rs2_imm"; end
      7'b0010111: begin fmt = "U"; writes = 1; e.b_sel = 1; mn = "add"; e.cls[5] = 1; end
      7'b1101111: begin fmt = "J"; writes = 1; e.b_sel = 1; mn = "add"; e.cls[3] = 1; end
      7'b1100111: begin fmt = "I"; writes = 1; e.b_sel = 1; mn = "add"; e.cls[4] = 1; ok = (f3 == 0); end
      7'b0000011: begin
        fmt = "I"; writes = 1; e.b_sel = 1; mn = "add"; e.cls[0] = 1;
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'b0100011: begin fmt = "S"; e.b_sel = 1; mn = "add"; e.cls[1] = 1; ok = (f3 <= 2); end
      7'b0001111: ok = FENCE_AS_NOP;
      default:    ok = 0;
    endcase
    if (!ok) begin
      e.op = '0; e.cls = '0; e.rd_we = 0; e.b_sel = 0; e.imm = '0; e.illegal = 1;
      return e;
    end
    if (mn != "") e.op[op_index(mn)] = 1'b1;
    case (fmt)
      "I":     imm = $signed(w[31:20]);
      "S":     imm = $signed({w[31:25], w[11:7]});
      "B":     imm = $signed({w[31], w[7], w[30:25], w[11:8]}) * 2;
      "U":     imm = int'(w[31:12]) * 4096;
      "J":     imm = $signed({w[31], w[19:12], w[20], w[30:21]}) * 2;
      default: imm = 0;
    endcase
    e.imm = imm;
    e.rd_we = writes && !(X0_NO_WE && w[11:7] == 5'd0);
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.pc = bus.dec_pc_o; o.rs1 = bus.rs1_o; o.rs2 = bus.rs2_o; o.rd = bus.rd_o;
    o.rd_we = bus.rd_we_o; o.imm = bus.imm_o; o.b_sel = bus.b_sel_imm_o;
    o.op = bus.op_o; o.cls = bus.cls_o; o.illegal = bus.illegal_o;
    return o;
  endfunction

  // Drive one cycle from a falling edge, advance the handshake model at the rising edge,
  // and return on the next falling edge with outputs settled.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    bus.instr_valid_i = v; bus.instr_i = w; bus.pc_i = pc; bus.dec_ready_i = rdy; bus.flush_i = fl;
    #1;
    seen_ready = bus.instr_ready_o;
    exp_ready  = fl | ~m_valid | rdy;
    @(posedge clk);
    if (fl)                   m_valid = 1'b0;
    else if (v && exp_ready) begin m_valid = 1'b1; m_out = ref_decode(w, pc); end
    else if (rdy)             m_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.instr_valid_i = 0; bus.instr_i = '0; bus.pc_i = '0; bus.dec_ready_i = 0; bus.flush_i = 0;
  endtask

  task automatic test_reset();
    idle();
    #12;
    n_total++; if (bus.dec_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.dec_valid_o); else n_pass++;
    n_total++; if (observe() !== exp_t'('0)) $display("FAIL reset_outputs: got %h want 0", observe()); else n_pass++;
    n_total++; if (bus.instr_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.instr_ready_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    step(1, 32'h002081B3, 32'h0000_1000, 1, 0);
    n_total++; if (bus.dec_valid_o !== 1'b1) $display("FAIL add_valid: got %b want 1", bus.dec_valid_o); else n_pass++;
    n_total++; if (bus.op_o !== 15'h0001) $display("FAIL add_op: got %h want 0001", bus.op_o); else n_pass++;
    n_total++; if (bus.rd_o !== 5'd3 || bus.rd_we_o !== 1'b1 || bus.b_sel_imm_o !== 1'b0)
      $display("FAIL add_rd: got rd=%0d we=%b bsel=%b want 3/1/0", bus.rd_o, bus.rd_we_o, bus.b_sel_imm_o); else n_pass++;
    n_total++; if (bus.dec_pc_o !== 32'h0000_1000) $display("FAIL add_pc: got %h want 00001000", bus.dec_pc_o); else n_pass++;
    step(1, 32'hFE20FEE3, 32'h0000_1004, 1, 0);
    n_total++; if (bus.op_o !== 15'h0010 || bus.cls_o !== 6'h04)
      $display("FAIL bgeu_op: got op=%h cls=%h want 0010/04", bus.op_o, bus.cls_o); else n_pass++;
    n_total++; if (bus.imm_o !== 32'hFFFFFFFC || bus.rd_we_o !== 1'b0)
      $display("FAIL bgeu_imm: got imm=%h we=%b want fffffffc/0", bus.imm_o, bus.rd_we_o); else n_pass++;
    step(1, 32'h123452B7, 32'h0000_1008, 1, 0);
    n_total++; if (bus.op_o !== 15'h0200 || bus.imm_o !== 32'h12345000 || bus.rd_o !== 5'd5)
      $display("FAIL lui: got op=%h imm=%h rd=%0d want 0200/12345000/5", bus.op_o, bus.imm_o, bus.rd_o); else n_pass++;
    step(1, 32'h00100013, 32'h0000_100C, 1, 0);
    n_total++; if (bus.rd_we_o !== 1'b0 || bus.op_o !== 15'h0001 || bus.imm_o !== 32'd1)
      $display("FAIL addi_x0: got we=%b op=%h imm=%h want 0/0001/1", bus.rd_we_o, bus.op_o, bus.imm_o); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] srai_bad;
    srai_bad = {7'b0000001, 5'd1, 5'd1, 3'b101, 5'd1, 7'b0010011};
    step(1, 32'h00000073, 32'h0000_2000, 1, 0);
    n_total++; if (bus.illegal_o !== 1'b1 || bus.op_o !== 15'h0 || bus.cls_o !== 6'h0 || bus.rd_we_o !== 1'b0)
      $display("FAIL ecall: got ill=%b op=%h cls=%h we=%b want 1/0/0/0", bus.illegal_o, bus.op_o, bus.cls_o, bus.rd_we_o); else n_pass++;
    step(1, srai_bad, 32'h0000_2004, 1, 0);
    n_total++; if (bus.illegal_o !== 1'b1 || bus.op_o !== 15'h0 || bus.rd_we_o !== 1'b0)
      $display("FAIL srai_f7: got ill=%b op=%h we=%b want 1/0/0", bus.illegal_o, bus.op_o, bus.rd_we_o); else n_pass++;
    step(1, 32'h0FF0000F, 32'h0000_2008, 1, 0);
    n_total++; if (bus.illegal_o !== 1'b0 || bus.op_o !== 15'h0 || bus.cls_o !== 6'h0 || bus.rd_we_o !== 1'b0)
      $display("FAIL fence: got ill=%b op=%h cls=%h we=%b want 0/0/0/0", bus.illegal_o, bus.op_o, bus.cls_o, bus.rd_we_o); else n_pass++;
  endtask

  task automatic test_hold();
    step(1, 32'h002081B3, 32'h0000_3000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h40208233, 32'h0000_3004, 0, 0);
      n_total++; if (seen_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %b want 0", i, seen_ready); else n_pass++;
      n_total++; if (bus.dec_valid_o !== 1'b1 || bus.dec_pc_o !== 32'h0000_3000 || bus.op_o !== 15'h0001)
        $display("FAIL hold_stable[%0d]: got v=%b pc=%h op=%h want 1/00003000/0001", i, bus.dec_valid_o, bus.dec_pc_o, bus.op_o); else n_pass++;
    end
    step(1, 32'h40208233, 32'h0000_3004, 1, 0);
    n_total++; if (seen_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", seen_ready); else n_pass++;
    n_total++; if (bus.dec_pc_o !== 32'h0000_3004 || bus.op_o !== 15'h2000 || bus.dec_valid_o !== 1'b1)
      $display("FAIL release_next: got pc=%h op=%h v=%b want 00003004/2000/1", bus.dec_pc_o, bus.op_o, bus.dec_valid_o); else n_pass++;
    step(0, 32'h0, 32'h0, 1, 0);
    n_total++; if (bus.dec_valid_o !== 1'b0 || bus.dec_pc_o !== 32'h0000_3004)
      $display("FAIL drain: got v=%b pc=%h want 0/00003004", bus.dec_valid_o, bus.dec_pc_o); else n_pass++;
  endtask

  task automatic test_flush();
    step(1, 32'h002081B3, 32'h0000_4000, 0, 0);
    step(1, 32'h123452B7, 32'h0000_4004, 0, 1);
    n_total++; if (seen_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", seen_ready); else n_pass++;
    n_total++; if (bus.dec_valid_o !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.dec_valid_o); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step(0, 32'h0, 32'h0, 1, 0);
      n_total++; if (bus.dec_valid_o !== 1'b0 || bus.dec_pc_o === 32'h0000_4004)
        $display("FAIL flush_dropped[%0d]: got v=%b pc=%h want 0/not 00004004", i, bus.dec_valid_o, bus.dec_pc_o); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_hold();
    step(1, 32'h002081B3, 32'h0000_5000, 1, 0);
    step(1, 32'h00100013, 32'h0000_5004, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.dec_valid_o !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", bus.dec_valid_o); else n_pass++;
    n_total++; if (observe() !== exp_t'('0)) $display("FAIL async_reset_data: got %h want 0", observe()); else n_pass++;
    m_valid = 1'b0; m_out = '0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [6:0] opcs [12] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h00};
    logic [6:0] f7s [3];
    logic [31:0] w;
    exp_t o;
    for (int i = 0; i < 1500; i++) begin
      w = $urandom;
      w[6:0] = opcs[$urandom_range(0, 11)];
      if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
      f7s = '{7'h00, 7'h20, 7'($urandom)};
      w[31:25] = f7s[$urandom_range(0, 2)];
      step($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      n_total++; if (seen_ready !== exp_ready) $display("FAIL rand_ready[%0d]: got %b want %b", i, seen_ready, exp_ready); else n_pass++;
      n_total++; if (bus.dec_valid_o !== m_valid) $display("FAIL rand_valid[%0d]: got %b want %b", i, bus.dec_valid_o, m_valid); else n_pass++;
      o = observe();
      if (m_out.illegal) begin o.imm = m_out.imm; o.b_sel = m_out.b_sel; end
      n_total++; if (o !== m_out) $display("FAIL rand_data[%0d]: got %h want %h", i, o, m_out); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_hold();
    test_flush();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
